// File: rtl/signal_monitor_pkg.sv
// Shared types and constants for signal_monitor (package mon_pkg).
// Enables/disables nothing itself; see signal_monitor.sv for MON_SEQ_CHECK_EN.
package mon_pkg;

    typedef enum logic [2:0] {
        FLT_NONE      = 3'd0,
        FLT_CONFLICT  = 3'd1,
        FLT_DARK      = 3'd2,
        FLT_MULTI     = 3'd3,
        FLT_SEQ       = 3'd4,
        FLT_SHORT_YEL = 3'd5,
        FLT_SEG       = 3'd6
    } fault_e;

    typedef enum logic [2:0] {
        LAMP_OFF,
        LAMP_R,
        LAMP_Y,
        LAMP_G,
        LAMP_MULTI
    } lamp_e;

    // Active-low seven-segment codes, bit 0 = segment a, bit 6 = segment g
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Controller bus bit map
    localparam int LAMP_W    = 3;
    localparam int SEG_W     = 7;
    localparam int LAMP_A_LO = 0;
    localparam int LAMP_B_LO = 3;
    localparam int SEG_A_LO  = 10;
    localparam int SEG_B_LO  = 17;
    // Packed internal vector: [2:0] lamp A, [5:3] lamp B, [12:6] seg A, [19:13] seg B
    localparam int SYNC_W    = 2 * LAMP_W + 2 * SEG_W;

    // Lamp vector {green, yellow, red} to lamp state
    function automatic lamp_e lamp_class(input logic [2:0] v);
        case (v)
            3'b000:  return LAMP_OFF;
            3'b001:  return LAMP_R;
            3'b010:  return LAMP_Y;
            3'b100:  return LAMP_G;
            default: return LAMP_MULTI;
        endcase
    endfunction

    function automatic logic is_single(input lamp_e l);
        return (l == LAMP_R) || (l == LAMP_Y) || (l == LAMP_G);
    endfunction

    function automatic logic seq_legal(input lamp_e p, input lamp_e c);
        return ((p == LAMP_R) && (c == LAMP_G)) ||
               ((p == LAMP_G) && (c == LAMP_Y)) ||
               ((p == LAMP_Y) && (c == LAMP_R));
    endfunction

endpackage

// File: rtl/signal_monitor_seg7_decode.sv
// Seven-segment decoder: active-low code in, {valid, digit} out.
// Blank decodes as valid with digit 4'hF; unknown codes are invalid with 4'hF.
module seg7_decode
    import mon_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [4:0] dec_o
);

    // Map each legal pattern to its digit
    always_comb begin
        dec_o = {1'b0, 4'hF};
        case (seg_i)
            SEG_0:     dec_o = {1'b1, 4'd0};
            SEG_1:     dec_o = {1'b1, 4'd1};
            SEG_2:     dec_o = {1'b1, 4'd2};
            SEG_3:     dec_o = {1'b1, 4'd3};
            SEG_4:     dec_o = {1'b1, 4'd4};
            SEG_5:     dec_o = {1'b1, 4'd5};
            SEG_6:     dec_o = {1'b1, 4'd6};
            SEG_7:     dec_o = {1'b1, 4'd7};
            SEG_8:     dec_o = {1'b1, 4'd8};
            SEG_9:     dec_o = {1'b1, 4'd9};
            SEG_BLANK: dec_o = {1'b1, 4'hF};
            default:   dec_o = {1'b0, 4'hF};
        endcase
    end

endmodule

// File: rtl/signal_monitor.sv
// Receive-side safety monitor for the traffic-light GPIO bus.
// Optional MON_SEQ_CHECK_EN adds sequence and minimum-yellow checking.
module signal_monitor
    import mon_pkg::*;
#(
    parameter int DEBOUNCE_CYC   = 4,
    parameter int MIN_YELLOW_CYC = 50_000_000
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [23:0] gpio_i,
    input  logic        clear_i,
    output logic        fault_o,
    output logic [2:0]  fault_code_o,
    output logic        fault_dir_o,
    output logic [2:0]  lamp_a_o,
    output logic [2:0]  lamp_b_o,
    output logic [3:0]  digit_a_o,
    output logic [3:0]  digit_b_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC + 1);

    logic [SYNC_W-1:0] bus_in, sync1_q, sync2_q, last_q;
    logic [CW-1:0]     cnt_q;
    logic              load, upd_q;
    logic [4:0]        dec_a, dec_b;
    logic              seg_ok_q [2];
    lamp_e             cur [2];
    logic              conflict;
    logic              dark [2], multi [2], seq_bad [2], short_bad [2], seg_bad [2];
    fault_e            fault_q, code_n;
    logic              dir_n;

    assign bus_in = {gpio_i[SEG_B_LO +: SEG_W], gpio_i[SEG_A_LO +: SEG_W],
                     gpio_i[LAMP_B_LO +: LAMP_W], gpio_i[LAMP_A_LO +: LAMP_W]};

    // Two-flop synchroniser and stability counter; the counter starts saturated
    // so the all-zero reset value is never reported as a stable bus state
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            last_q  <= '0;
            cnt_q   <= CW'(DEBOUNCE_CYC);
        end else begin
            sync1_q <= bus_in;
            sync2_q <= sync1_q;
            if (sync2_q != last_q) begin
                last_q <= sync2_q;
                cnt_q  <= CW'(1);
            end else if (cnt_q != CW'(DEBOUNCE_CYC)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // Load when the current sample is the DEBOUNCE_CYC-th identical one
    always_comb begin
        if (sync2_q != last_q) load = (DEBOUNCE_CYC == 1);
        else                   load = (cnt_q == CW'(DEBOUNCE_CYC - 1));
    end

    seg7_decode u_dec_a (.seg_i(sync2_q[12:6]),  .dec_o(dec_a));
    seg7_decode u_dec_b (.seg_i(sync2_q[19:13]), .dec_o(dec_b));

    // Stable register: lamps, decoded digits and segment validity
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            lamp_a_o  <= '0;
            lamp_b_o  <= '0;
            digit_a_o <= '1;
            digit_b_o <= '1;
            seg_ok_q  <= '{1'b1, 1'b1};
            upd_q     <= 1'b0;
        end else begin
            upd_q <= load;
            if (load) begin
                lamp_a_o    <= sync2_q[2:0];
                lamp_b_o    <= sync2_q[5:3];
                digit_a_o   <= dec_a[3:0];
                digit_b_o   <= dec_b[3:0];
                seg_ok_q[0] <= dec_a[4];
                seg_ok_q[1] <= dec_b[4];
            end
        end
    end

    assign cur[0] = lamp_class(lamp_a_o);
    assign cur[1] = lamp_class(lamp_b_o);

`ifdef MON_SEQ_CHECK_EN
    localparam int              TW      = $clog2(MIN_YELLOW_CYC + 1);
    localparam logic [TW-1:0]   YEL_MIN = TW'(MIN_YELLOW_CYC);

    logic [TW-1:0] ytmr_q [2];
    lamp_e         prev_q [2];
    lamp_e         nxt [2];
    logic          hist_q [2];

    assign nxt[0] = lamp_class(sync2_q[2:0]);
    assign nxt[1] = lamp_class(sync2_q[5:3]);

    // Yellow timers: cleared on the load that enters yellow, then count while
    // yellow; the edge that loads red still counts, so the value equals the
    // number of cycles yellow was stable
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            ytmr_q <= '{'0, '0};
        end else begin
            for (int unsigned d = 0; d < 2; d++) begin
                if (load && nxt[d] == LAMP_Y && cur[d] != LAMP_Y)
                    ytmr_q[d] <= '0;
                else if (cur[d] == LAMP_Y && ytmr_q[d] != '1)
                    ytmr_q[d] <= ytmr_q[d] + 1'b1;
            end
        end
    end

    // Sequence history, advanced on each update strobe
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            prev_q <= '{LAMP_OFF, LAMP_OFF};
            hist_q <= '{1'b0, 1'b0};
        end else if (upd_q) begin
            for (int unsigned d = 0; d < 2; d++) begin
                if (is_single(cur[d])) begin
                    prev_q[d] <= cur[d];
                    hist_q[d] <= 1'b1;
                end else begin
                    hist_q[d] <= 1'b0;
                end
            end
        end
    end

    // Transition checks against the previous one-lamp state
    always_comb begin
        for (int unsigned d = 0; d < 2; d++) begin
            seq_bad[d]   = 1'b0;
            short_bad[d] = 1'b0;
            if (hist_q[d] && is_single(cur[d])) begin
                seq_bad[d]   = (cur[d] != prev_q[d]) && !seq_legal(prev_q[d], cur[d]);
                short_bad[d] = (prev_q[d] == LAMP_Y) && (cur[d] == LAMP_R) &&
                               (ytmr_q[d] < YEL_MIN);
            end
        end
    end
`else
    assign seq_bad   = '{1'b0, 1'b0};
    assign short_bad = '{1'b0, 1'b0};
`endif

    assign conflict   = (lamp_a_o[2] | lamp_a_o[1]) & (lamp_b_o[2] | lamp_b_o[1]);
    assign dark[0]    = (cur[0] == LAMP_OFF);
    assign dark[1]    = (cur[1] == LAMP_OFF);
    assign multi[0]   = (cur[0] == LAMP_MULTI);
    assign multi[1]   = (cur[1] == LAMP_MULTI);
    assign seg_bad[0] = !seg_ok_q[0];
    assign seg_bad[1] = !seg_ok_q[1];

    // Priority pick: lowest code first, direction A before B
    always_comb begin
        code_n = FLT_NONE;
        dir_n  = 1'b0;
        if      (conflict)     begin code_n = FLT_CONFLICT;  dir_n = 1'b0; end
        else if (dark[0])      begin code_n = FLT_DARK;      dir_n = 1'b0; end
        else if (dark[1])      begin code_n = FLT_DARK;      dir_n = 1'b1; end
        else if (multi[0])     begin code_n = FLT_MULTI;     dir_n = 1'b0; end
        else if (multi[1])     begin code_n = FLT_MULTI;     dir_n = 1'b1; end
        else if (seq_bad[0])   begin code_n = FLT_SEQ;       dir_n = 1'b0; end
        else if (seq_bad[1])   begin code_n = FLT_SEQ;       dir_n = 1'b1; end
        else if (short_bad[0]) begin code_n = FLT_SHORT_YEL; dir_n = 1'b0; end
        else if (short_bad[1]) begin code_n = FLT_SHORT_YEL; dir_n = 1'b1; end
        else if (seg_bad[0])   begin code_n = FLT_SEG;       dir_n = 1'b0; end
        else if (seg_bad[1])   begin code_n = FLT_SEG;       dir_n = 1'b1; end
    end

    // Fault latch: first fault sticks, clear overrides a same-cycle fault
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            fault_o     <= 1'b0;
            fault_q     <= FLT_NONE;
            fault_dir_o <= 1'b0;
        end else if (clear_i) begin
            fault_o     <= 1'b0;
            fault_q     <= FLT_NONE;
            fault_dir_o <= 1'b0;
        end else if (!fault_o && upd_q && code_n != FLT_NONE) begin
            fault_o     <= 1'b1;
            fault_q     <= code_n;
            fault_dir_o <= dir_n;
        end
    end

    assign fault_code_o = fault_q;

endmodule
